// File: rtl/register_file_1r_1w_mbist_wrap_if.sv
// Port bundle for register_file_1r_1w_mbist_wrap: functional port, external
// BIST port and MBIST engine control/status.
// Optional feature macro: MBIST_ERR_LOG_EN adds mbist_err_addr / mbist_err_data.
interface register_file_1r_1w_mbist_wrap_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  ReadEnable;
  logic [ADDR_WIDTH-1:0] ReadAddr;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  BIST;
  logic                  CSN_T;
  logic                  WEN_T;
  logic [ADDR_WIDTH-1:0] A_T;
  logic [DATA_WIDTH-1:0] D_T;
  logic [DATA_WIDTH-1:0] Q_T;
  logic                  mbist_start;
  logic                  mbist_busy;
  logic                  mbist_done;
  logic                  mbist_fail;
`ifdef MBIST_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] mbist_err_addr;
  logic [DATA_WIDTH-1:0] mbist_err_data;
`endif

  modport master (
    output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData,
    output BIST, CSN_T, WEN_T, A_T, D_T, mbist_start,
`ifdef MBIST_ERR_LOG_EN
    input  mbist_err_addr, mbist_err_data,
`endif
    input  ReadData, Q_T, mbist_busy, mbist_done, mbist_fail
  );

  modport slave (
    input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData,
    input  BIST, CSN_T, WEN_T, A_T, D_T, mbist_start,
`ifdef MBIST_ERR_LOG_EN
    output mbist_err_addr, mbist_err_data,
`endif
    output ReadData, Q_T, mbist_busy, mbist_done, mbist_fail
  );
endinterface

// File: rtl/register_file_1r_1w_mbist_wrap.sv
// 1R1W register file with a three-way port mux (MBIST engine > external BIST
// port > functional) and an on-chip March C- engine reporting done/fail.
// Optional feature macro: MBIST_ERR_LOG_EN logs address and read data of the
// first miscompare on mbist_err_addr / mbist_err_data.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | engine idle, array owned by BIST port / functional port
// S_M0    | up/down w0 over all tested words
// S_M1    | ascending (r0, w1)
// S_M2    | ascending (r1, w0)
// S_M3    | descending (r0, w1)
// S_M4    | descending (r1, w0)
// S_M5    | up/down r0
// S_GAP   | 2 idle cycles so the last write settles before the next element
// S_DRAIN | 2 cycles for the final read compare to complete
// S_DONE  | idle with done held; accepts a new start

module register_file_1r_1w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] WriteData
);
  localparam int NUM_ALL = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] words [NUM_ALL];

  for (genvar i = 0; i < NUM_ALL; i++) begin : g_word
    logic [DATA_WIDTH-1:0] word_q;
    // each word loads only when addressed; storage is never reset
    always_ff @(posedge clk) begin
      if (WriteEnable && (WriteAddr == ADDR_WIDTH'(i))) word_q <= WriteData;
    end
    assign words[i] = word_q;
  end

  // registered read samples the pre-write word on a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ReadData <= '0;
    else if (ReadEnable) ReadData <= words[ReadAddr];
  end
endmodule

module register_file_1r_1w_mbist_wrap #(
  parameter int                        ADDR_WIDTH  = 5,
  parameter int                        DATA_WIDTH  = 32,
  parameter int                        NUM_WORDS   = 2**ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]     MBIST_BKGND = '0
) (
  input logic                           clk,
  input logic                           rst,
  register_file_1r_1w_mbist_wrap_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_GAP, S_DRAIN, S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] D0   = MBIST_BKGND;
  localparam logic [DATA_WIDTH-1:0] D1   = ~MBIST_BKGND;

  state_e                state_q, state_d;
  state_e                ret_q, ret_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pair_wr_q, pair_wr_d;
  logic [1:0]            tmr_q, tmr_d;
  logic                  cmp_vld_q;
  logic [DATA_WIDTH-1:0] cmp_exp_q;
  logic                  done_q, fail_q;
`ifdef MBIST_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] cmp_addr_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [DATA_WIDTH-1:0] err_data_q;
`endif

  logic                  eng_re, eng_we;
  logic [DATA_WIDTH-1:0] eng_wdata, eng_exp;
  logic                  start_ok, set_done;
  logic                  elem_desc;
  logic [ADDR_WIDTH-1:0] elem_term;
  logic [DATA_WIDTH-1:0] rd_bg;
  logic                  busy, miscmp;

  logic                  rf_re, rf_we;
  logic [ADDR_WIDTH-1:0] rf_raddr, rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata, rf_rdata;

  function automatic state_e next_elem(input state_e s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      default: return S_DRAIN;
    endcase
  endfunction

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign miscmp = cmp_vld_q && (rf_rdata != cmp_exp_q);

  // March sequencing: next state, address walk and array operation per cycle
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    addr_d    = addr_q;
    pair_wr_d = pair_wr_q;
    tmr_d     = tmr_q;
    eng_re    = 1'b0;
    eng_we    = 1'b0;
    eng_wdata = D0;
    eng_exp   = D0;
    start_ok  = 1'b0;
    set_done  = 1'b0;
    elem_desc = (state_q == S_M3) || (state_q == S_M4);
    elem_term = elem_desc ? '0 : LAST;
    rd_bg     = ((state_q == S_M2) || (state_q == S_M4)) ? D1 : D0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.mbist_start) begin
          state_d   = S_M0;
          addr_d    = '0;
          pair_wr_d = 1'b0;
          start_ok  = 1'b1;
        end
      end
      S_M0: begin
        eng_we    = 1'b1;
        eng_wdata = D0;
        if (addr_q == LAST) begin
          state_d = S_GAP;
          ret_d   = S_M1;
          tmr_d   = 2'd1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        if (!pair_wr_q) begin
          eng_re    = 1'b1;
          eng_exp   = rd_bg;
          pair_wr_d = 1'b1;
        end else begin
          eng_we    = 1'b1;
          eng_wdata = ~rd_bg;
          pair_wr_d = 1'b0;
          if (addr_q == elem_term) begin
            state_d = S_GAP;
            ret_d   = next_elem(state_q);
            tmr_d   = 2'd1;
          end else begin
            addr_d = elem_desc ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
      S_M5: begin
        eng_re  = 1'b1;
        eng_exp = D0;
        if (addr_q == LAST) begin
          state_d = S_DRAIN;
          tmr_d   = 2'd1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q == 2'd0) begin
          state_d = ret_q;
          addr_d  = ((ret_q == S_M3) || (ret_q == S_M4)) ? LAST : '0;
        end else begin
          tmr_d = tmr_q - 2'd1;
        end
      end
      S_DRAIN: begin
        if (tmr_q == 2'd0) begin
          state_d  = S_DONE;
          set_done = 1'b1;
        end else begin
          tmr_d = tmr_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // engine state, compare pipeline and sticky status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      addr_q    <= '0;
      pair_wr_q <= 1'b0;
      tmr_q     <= 2'd0;
      cmp_vld_q <= 1'b0;
      cmp_exp_q <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
`ifdef MBIST_ERR_LOG_EN
      cmp_addr_q <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      addr_q    <= addr_d;
      pair_wr_q <= pair_wr_d;
      tmr_q     <= tmr_d;
      cmp_vld_q <= eng_re;
      cmp_exp_q <= eng_exp;
`ifdef MBIST_ERR_LOG_EN
      cmp_addr_q <= addr_q;
`endif
      if (start_ok) begin
        done_q <= 1'b0;
        fail_q <= 1'b0;
`ifdef MBIST_ERR_LOG_EN
        err_addr_q <= '0;
        err_data_q <= '0;
`endif
      end else begin
        if (set_done) done_q <= 1'b1;
        if (miscmp)   fail_q <= 1'b1;
`ifdef MBIST_ERR_LOG_EN
        if (miscmp && !fail_q) begin
          err_addr_q <= cmp_addr_q;
          err_data_q <= rf_rdata;
        end
`endif
      end
    end
  end

  // port mux: engine while busy, else external BIST port, else functional
  always_comb begin
    rf_re    = bus.ReadEnable;
    rf_raddr = bus.ReadAddr;
    rf_we    = bus.WriteEnable;
    rf_waddr = bus.WriteAddr;
    rf_wdata = bus.WriteData;
    if (busy) begin
      rf_re    = eng_re;
      rf_raddr = addr_q;
      rf_we    = eng_we;
      rf_waddr = addr_q;
      rf_wdata = eng_wdata;
    end else if (bus.BIST) begin
      rf_re    = !bus.CSN_T && bus.WEN_T;
      rf_raddr = bus.A_T;
      rf_we    = !bus.CSN_T && !bus.WEN_T;
      rf_waddr = bus.A_T;
      rf_wdata = bus.D_T;
    end
  end

  register_file_1r_1w #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rf (
    .clk         (clk),
    .rst         (rst),
    .ReadEnable  (rf_re),
    .ReadAddr    (rf_raddr),
    .ReadData    (rf_rdata),
    .WriteEnable (rf_we),
    .WriteAddr   (rf_waddr),
    .WriteData   (rf_wdata)
  );

  assign bus.ReadData   = rf_rdata;
  assign bus.Q_T        = rf_rdata;
  assign bus.mbist_busy = busy;
  assign bus.mbist_done = done_q;
  assign bus.mbist_fail = fail_q;
`ifdef MBIST_ERR_LOG_EN
  assign bus.mbist_err_addr = err_addr_q;
  assign bus.mbist_err_data = err_data_q;
`endif
endmodule
